// File: rtl/cpu_step_controller.sv
// Execution sequencer for the single-cycle core: manual step, four-rate free-run and
// an optional PC breakpoint compiled in when CPU_STEP_BREAKPOINT_EN is defined.
module cpu_step_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned BASE_DIV        = 50000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step_btn_n,
   input  logic        run_sw,
   input  logic [1:0]  rate_sel,
   input  logic [31:0] pc_addr,
   input  logic [31:0] bp_addr,
   input  logic        bp_valid,
   output logic        cpu_en,
   output logic [1:0]  state,
   output logic        halted,
   output logic [31:0] step_count
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [31:0] PER0 = 32'(BASE_DIV);
   localparam logic [31:0] PER1 = 32'(BASE_DIV >> 2);
   localparam logic [31:0] PER2 = 32'(BASE_DIV >> 4);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BREAK = 2'd2
   } state_e;

   logic            btn_s1_q, btn_s2_q, run_s1_q, run_s2_q;
   logic            deb_q, deb_d, deb_dly_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            press_c;
   state_e          state_q, state_d;
   logic [31:0]     rate_cnt_q, rate_cnt_d, period_c;
   logic            due_c, bp_hit_c;
   logic            cpu_en_q, cpu_en_d;
   logic [31:0]     step_cnt_q, step_cnt_d;

   // Synchronizers and debounced button level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1_q  <= 1'b0;
         btn_s2_q  <= 1'b0;
         run_s1_q  <= 1'b0;
         run_s2_q  <= 1'b0;
         deb_q     <= 1'b1;
         deb_dly_q <= 1'b1;
         db_cnt_q  <= '0;
      end else begin
         btn_s1_q  <= step_btn_n;
         btn_s2_q  <= btn_s1_q;
         run_s1_q  <= run_sw;
         run_s2_q  <= run_s1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         db_cnt_q  <= db_cnt_d;
      end
   end

   // Level is accepted only after a full run of consecutive differing samples
   always_comb begin
      db_cnt_d = '0;
      deb_d    = deb_q;
      if (btn_s2_q != deb_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d = btn_s2_q;
         else                                       db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   assign press_c = deb_dly_q & ~deb_q;

   always_comb begin
      unique case (rate_sel)
         2'd0:    period_c = PER0;
         2'd1:    period_c = PER1;
         default: period_c = PER2;
      endcase
   end

   // >= lets a shortened period wrap at once when the count is already past it
   assign due_c = (rate_sel == 2'd3) || (rate_cnt_q >= (period_c - 32'd1));

   always_comb begin
      state_d    = state_q;
      rate_cnt_d = rate_cnt_q;
      cpu_en_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            rate_cnt_d = '0;
            if (press_c)  cpu_en_d = 1'b1;
            if (run_s2_q) state_d  = ST_RUN;
         end
         ST_RUN: begin
            if (!run_s2_q) begin
               state_d    = ST_IDLE;
               rate_cnt_d = '0;
            end else if (due_c) begin
               rate_cnt_d = '0;
               if (bp_hit_c) state_d  = ST_BREAK;
               else          cpu_en_d = 1'b1;
            end else begin
               rate_cnt_d = rate_cnt_q + 32'd1;
            end
         end
`ifdef CPU_STEP_BREAKPOINT_EN
         ST_BREAK: begin
            if (press_c) begin
               cpu_en_d = 1'b1;
               state_d  = ST_RUN;
            end else if (!run_s2_q) begin
               state_d  = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      step_cnt_d = cpu_en_d ? (step_cnt_q + 32'd1) : step_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rate_cnt_q <= '0;
         cpu_en_q   <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rate_cnt_q <= rate_cnt_d;
         cpu_en_q   <= cpu_en_d;
         step_cnt_q <= step_cnt_d;
      end
   end

`ifdef CPU_STEP_BREAKPOINT_EN
   logic halted_q;

   assign bp_hit_c = bp_valid && (pc_addr == bp_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halted_q <= 1'b0;
      else        halted_q <= (state_d == ST_BREAK);
   end

   assign halted = halted_q;
`else
   logic unused_bp;

   assign unused_bp = ^{pc_addr, bp_addr, bp_valid};
   assign bp_hit_c  = 1'b0;
   assign halted    = 1'b0;
`endif

   assign cpu_en     = cpu_en_q;
   assign state      = state_q;
   assign step_count = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: expected pulse cycles are queued as stimulus is
// driven and matched against every cpu_en pulse seen on the falling edge.
module tb_cpu_step_controller;

   localparam int unsigned DEB  = 4;
   localparam int unsigned BASE = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        step_btn_n = 1'b1;
   logic        run_sw = 1'b0;
   logic [1:0]  rate_sel = 2'd0;
   logic [31:0] pc_addr;
   logic [31:0] bp_addr = 32'd0;
   logic        bp_valid = 1'b0;
   logic        cpu_en;
   logic [1:0]  state;
   logic        halted;
   logic [31:0] step_count;

   int unsigned cyc = 0;
   logic        pc_clr = 1'b1;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned exp_q[$];
   logic [31:0] exp_steps = 32'd0;

   typedef struct {
      logic [1:0]  rate;
      int unsigned period;
      int unsigned n_on;
      int unsigned n_pulses;
   } vec_t;

   vec_t vecs[4];

   cpu_step_controller #(.DEBOUNCE_CYCLES(DEB), .BASE_DIV(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_btn_n (step_btn_n),
      .run_sw     (run_sw),
      .rate_sel   (rate_sel),
      .pc_addr    (pc_addr),
      .bp_addr    (bp_addr),
      .bp_valid   (bp_valid),
      .cpu_en     (cpu_en),
      .state      (state),
      .halted     (halted),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Core model: PC advances by one instruction per enable pulse
   always @(posedge clk) begin
      if (pc_clr)      pc_addr <= 32'd0;
      else if (cpu_en) pc_addr <= pc_addr + 32'd4;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One cycle: sample on the falling edge and match any pulse against the queue
   task automatic tick();
      @(negedge clk);
      if (rst_n && cpu_en) begin
         if (exp_q.size() == 0) begin
            n_chk = n_chk + 1;
            $display("FAIL unexpected_pulse: cpu_en high at cycle %0d with no pulse expected", cyc);
         end else begin
            chk("pulse_cycle", cyc, exp_q.pop_front());
         end
         chk("step_count_on_pulse", step_count, exp_steps + 32'd1);
         exp_steps = exp_steps + 32'd1;
      end
   endtask

   task automatic ticks(input int unsigned n);
      for (int i = 0; i < int'(n); i++) tick();
   endtask

   initial begin
      int unsigned c0;

      vecs[0] = '{rate: 2'd0, period: 64, n_on: 200, n_pulses: 3};
      vecs[1] = '{rate: 2'd1, period: 16, n_on: 100, n_pulses: 6};
      vecs[2] = '{rate: 2'd2, period: 4,  n_on: 20,  n_pulses: 4};
      vecs[3] = '{rate: 2'd3, period: 1,  n_on: 10,  n_pulses: 9};

      ticks(2);
      chk("reset_cpu_en", 32'(cpu_en), 32'd0);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      chk("reset_step_count", step_count, 32'd0);
      rst_n  = 1'b1;
      pc_clr = 1'b0;
      ticks(5);

      // Bouncing button never settles; the final hold gives exactly one step
      for (int i = 0; i < 10; i++) begin
         step_btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         ticks(2);
      end
      step_btn_n = 1'b0;
      exp_q.push_back(cyc + 7);
      ticks(12);
      chk("debounce_step_count", step_count, 32'd1);
      chk("debounce_missed", exp_q.size(), 32'd0);
      step_btn_n = 1'b1;
      ticks(10);

      foreach (vecs[v]) begin
         rate_sel = vecs[v].rate;
         run_sw   = 1'b1;
         c0       = cyc;
         for (int k = 1; k <= int'(vecs[v].n_pulses); k++)
            exp_q.push_back(c0 + 3 + int'(k) * vecs[v].period);
         ticks(2);
         chk("run_entry_idle", 32'(state), 32'd0);
         tick();
         chk("run_entry_run", 32'(state), 32'd1);
         ticks(vecs[v].n_on - 3);
         run_sw = 1'b0;
         ticks(2);
         chk("run_exit_still_run", 32'(state), 32'd1);
         tick();
         chk("run_exit_idle", 32'(state), 32'd0);
         ticks(5);
         chk("run_missed", exp_q.size(), 32'd0);
         chk("run_step_count", step_count, exp_steps);
      end

      // Rate shortened while the count is already past the new period
      rate_sel = 2'd0;
      run_sw   = 1'b1;
      c0       = cyc;
      ticks(33);
      rate_sel = 2'd2;
      exp_q.push_back(c0 + 34);
      exp_q.push_back(c0 + 38);
      ticks(6);
      run_sw = 1'b0;
      ticks(8);
      chk("rate_change_missed", exp_q.size(), 32'd0);

      // Stop mid-period, then confirm the next run starts from a cleared count
      rate_sel = 2'd0;
      run_sw   = 1'b1;
      c0       = cyc;
      ticks(33);
      run_sw = 1'b0;
      ticks(2);
      chk("stop_still_run", 32'(state), 32'd1);
      tick();
      chk("stop_idle", 32'(state), 32'd0);
      ticks(4);
      rate_sel = 2'd2;
      run_sw   = 1'b1;
      exp_q.push_back(cyc + 7);
      ticks(6);
      run_sw = 1'b0;
      ticks(8);
      chk("restart_missed", exp_q.size(), 32'd0);

`ifdef CPU_STEP_BREAKPOINT_EN
      pc_clr = 1'b1;
      tick();
      pc_clr   = 1'b0;
      bp_addr  = 32'h10;
      bp_valid = 1'b1;
      rate_sel = 2'd2;
      run_sw   = 1'b1;
      c0       = cyc;
      for (int k = 1; k <= 4; k++) exp_q.push_back(c0 + 3 + int'(k) * 4);
      ticks(22);
      chk("bp_pre_state", 32'(state), 32'd1);
      chk("bp_pre_halted", 32'(halted), 32'd0);
      tick();
      chk("bp_state", 32'(state), 32'd2);
      chk("bp_halted", 32'(halted), 32'd1);
      chk("bp_pc", pc_addr, 32'h10);
      ticks(3);
      chk("bp_hold_state", 32'(state), 32'd2);
      step_btn_n = 1'b0;
      c0         = cyc;
      exp_q.push_back(c0 + 7);
      exp_q.push_back(c0 + 11);
      ticks(7);
      chk("bp_resume_state", 32'(state), 32'd1);
      chk("bp_resume_halted", 32'(halted), 32'd0);
      step_btn_n = 1'b1;
      ticks(4);
      run_sw = 1'b0;
      ticks(8);
      chk("bp_missed", exp_q.size(), 32'd0);
      chk("bp_pc_after", pc_addr, 32'h18);
      bp_valid = 1'b0;
      ticks(6);
`else
      chk("halted_tied_low", 32'(halted), 32'd0);
`endif

      // Counter wrap from all-ones
      force dut.step_cnt_q = 32'hFFFF_FFFF;
      tick();
      release dut.step_cnt_q;
      exp_steps = 32'hFFFF_FFFF;
      tick();
      chk("wrap_preload", step_count, 32'hFFFF_FFFF);
      step_btn_n = 1'b0;
      exp_q.push_back(cyc + 7);
      ticks(8);
      chk("wrap_step_count", step_count, 32'd0);
      chk("wrap_missed", exp_q.size(), 32'd0);
      step_btn_n = 1'b1;
      ticks(10);

      // Reset asserted while a pulse is on the output
      rate_sel = 2'd3;
      run_sw   = 1'b1;
      c0       = cyc;
      for (int k = 4; k <= 7; k++) exp_q.push_back(c0 + int'(k));
      ticks(7);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun_reset_cpu_en", 32'(cpu_en), 32'd0);
      chk("midrun_reset_state", 32'(state), 32'd0);
      chk("midrun_reset_halted", 32'(halted), 32'd0);
      chk("midrun_reset_step_count", step_count, 32'd0);
      run_sw    = 1'b0;
      exp_steps = 32'd0;
      ticks(2);
      rst_n = 1'b1;
      ticks(8);
      chk("midrun_reset_missed", exp_q.size(), 32'd0);
      chk("post_reset_step_count", step_count, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_step_controller.md
# cpu_step_controller

Execution sequencer for the single-cycle RISC-V core. It turns the board's step button and run switch into a one-cycle `cpu_en` pulse that gates every state update in the core: PC, register file and data-memory writes. It supports manual single-step, free-run at four selectable rates, and an optional PC breakpoint. The core then runs on the 50 MHz system clock instead of a manually toggled clock, so the VGA debug monitor and the core share one clean clock domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz).
- `BASE_DIV`, default 50000000: run-mode period in cycles for `rate_sel`=0.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `step_btn_n`  in  1  step push button, active-low, asynchronous to `clk`.
- `run_sw`  in  1  run switch level, asynchronous to `clk`.
- `rate_sel`  in  2  run rate: period = `BASE_DIV >> (2*rate_sel)` for values 0..2; value 3 means every cycle.
- `pc_addr`  in  32  current PC from the core.
- `bp_addr`  in  32  breakpoint address.
- `bp_valid`  in  1  breakpoint armed.
- `cpu_en`  out  1  one-cycle enable: the core commits exactly one instruction per high cycle.
- `state`  out  2  FSM state: 0=IDLE, 1=RUN, 2=BREAK.
- `halted`  out  1  high while in BREAK.
- `step_count`  out  32  number of `cpu_en` pulses issued.

## Operation
- Input conditioning:
  - `step_btn_n` and `run_sw` each pass through a 2-flop synchronizer.
  - The button is debounced: the debounced level updates only after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. The counter clears on any bounce.
  - A press event is a debounced 1→0 transition.
- IDLE:
  - A press event produces one `cpu_en` pulse; the FSM stays in IDLE.
  - Synchronized `run_sw`=1 moves to RUN and clears the rate counter.
- RUN:
  - The rate counter counts up each cycle. At period−1 the block issues a pulse and the counter returns to 0.
  - With `rate_sel`=3, a pulse is issued every cycle.
  - Press events are ignored.
  - `run_sw`=0 moves to IDLE; the counter clears and no further pulse is issued.
  - A change to `rate_sel` takes effect on the next counter wrap. If the counter already exceeds the new period−1, it wraps immediately on the next cycle.
- BREAK (`BREAKPOINT_EN` only):
  - Entered from RUN when a pulse is due and `bp_valid`=1 with `pc_addr`==`bp_addr`. That pulse is suppressed.
  - A press event issues one pulse that bypasses the breakpoint check, then returns to RUN. Synchronized `run_sw` is sampled at that point, so a RUN/`run_sw`=0 combination resolves to IDLE one cycle later.
  - `run_sw`=0 moves to IDLE with no pulse.
- Breakpoints are not checked in IDLE; manual stepping always executes.
- `step_count` increments by 1 on every `cpu_en` pulse and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: `cpu_en`=0, `state`=IDLE, `halted`=0, `step_count`=0. Synchronizers, debounced level (reset to 1, released), debounce counter and rate counter are all cleared.
- All outputs are registered.
- Step latency: `step_btn_n` held low from cycle 0 → `cpu_en` high in cycle 2 + `DEBOUNCE_CYCLES` + 1, for exactly one cycle.
- Run entry: `run_sw` rises at cycle 0 → `state`=RUN visible at cycle 3. The first pulse comes one full period later; at `rate_sel`=3 it comes at cycle 4.
- Breakpoint entry: `state`=BREAK and `halted`=1 in the cycle the suppressed pulse would have appeared.
- `cpu_en` is never high for two consecutive cycles except at `rate_sel`=3.
- Reset asserted mid-pulse forces `cpu_en` low asynchronously. Any pending press event is discarded.

## Configuration
- `CPU_STEP_BREAKPOINT_EN` defined: the `pc_addr`/`bp_addr` comparator and the BREAK state are compiled in.
- Undefined: `bp_addr`, `bp_valid` and `pc_addr` are unused, BREAK is unreachable, and `halted` is tied to 0.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `BASE_DIV`=64.
- Reset: `rst_n` low mid-run → all outputs reset values within the same cycle; `step_count`=0.
- Debounce: `step_btn_n` toggles every 2 cycles for 20 cycles, then held low → no pulse during bouncing; exactly one `cpu_en` pulse 7 cycles after the hold begins; `step_count`=1.
- Run rates: `run_sw`=1 for 200 cycles at `rate_sel`=0 → pulses every 64 cycles. At `rate_sel`=1 → every 16. At `rate_sel`=3 → every cycle from cycle 4.
- Breakpoint: `bp_addr`=0x10, `bp_valid`=1, PC advanced by 4 per pulse from 0 → pulses at PC 0,4,8,C; BREAK at PC 0x10 with `halted`=1. A press then issues one pulse and the FSM resumes RUN.
- Stop mid-period: `run_sw` falls at counter=30 → no pulse issued; `state`=IDLE 3 cycles later. A later run restarts with counter=0.
- Wrap: force `step_count` to 0xFFFFFFFF, issue one step → `step_count`=0.
